adapt_speed_state: RTL and testbench

// - Downstream neighbour of the long-/short-term FI averaging filters in the decoder's quantizer scale-factor adaptation path.
// - Once per sample, registers DMSP->DMS and DMLP->DML, which feed back to those filters.
// - Derives the adaptation-speed decision AX (SUBTC), updates the speed control AP (FILTC + TRIGA), and exposes the limited speed control AL (LIMA).

---
 rtl/adapt_speed_state.sv | 131 +++++++++++++
 tb/tb_adapt_speed_state.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adapt_speed_state.sv
// rtl/adapt_speed_state.sv - DMS/DML delay, AX decision and AP/AL speed control for scale-factor adaptation
// Optional tone-detect gating of AX is enabled by defining TONE_DET_EN.
module adapt_speed_state #(
    parameter int Y_THR   = 1536,
    parameter int AP_TRIG = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        samp_en,
    input  logic [11:0] DMSP,
    input  logic [13:0] DMLP,
    input  logic [12:0] Y,
    input  logic        TDP,
    input  logic        TR,
    output logic [11:0] DMS,
    output logic [13:0] DML,
    output logic [9:0]  AP,
    output logic [6:0]  AL,
    output logic        AX,
    output logic        busy,
    output logic        done
);

    localparam logic [12:0] Y_THR_C   = 13'(Y_THR);
    localparam logic [9:0]  AP_TRIG_C = 10'(AP_TRIG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_FILT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // DMS/DML double as the latched DMSP/DMLP: they load on the same edge.
    logic [11:0] dms_q, dms_d;
    logic [13:0] dml_q, dml_d;
    logic [12:0] y_q, y_d;
    logic        tdp_q, tdp_d;
    logic        tr_q, tr_d;
    logic [9:0]  ap_q, ap_d;
    logic        ax_q, ax_d;
    logic        done_q, done_d;

    logic        tdpg;
    logic [15:0] dif, difm, dthr;
    logic [10:0] dd;
    logic [9:0]  dsx, app;

`ifdef TONE_DET_EN
    assign tdpg = tdp_q;
`else
    // G.721 mode: the tone flag is still latched but never gates AX.
    assign tdpg = 1'b0 & tdp_q;
`endif

    always_comb begin
        state_d = state_q;
        dms_d   = dms_q;
        dml_d   = dml_q;
        y_d     = y_q;
        tdp_d   = tdp_q;
        tr_d    = tr_q;
        ap_d    = ap_q;
        ax_d    = ax_q;
        done_d  = 1'b0;

        dif  = {2'b00, dms_q, 2'b00} + 16'h8000 - {2'b00, dml_q};
        difm = dif[15] ? ((~dif + 16'd1) & 16'h7FFF) : dif;
        dthr = {5'b0, dml_q[13:3]};

        dd   = {ax_q, 9'b0} - {1'b0, ap_q};
        dsx  = dd[10] ? ({3'b0, dd[10:4]} + 10'd896) : {3'b0, dd[10:4]};
        app  = dsx + ap_q;

        case (state_q)
            S_IDLE: begin
                if (samp_en) begin
                    dms_d   = DMSP;
                    dml_d   = DMLP;
                    y_d     = Y;
                    tdp_d   = TDP;
                    tr_d    = TR;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                ax_d    = !((y_q >= Y_THR_C) && (difm < dthr) && !tdpg);
                state_d = S_FILT;
            end
            S_FILT: begin
                ap_d    = tr_q ? AP_TRIG_C : app;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dms_q   <= '0;
            dml_q   <= '0;
            y_q     <= '0;
            tdp_q   <= 1'b0;
            tr_q    <= 1'b0;
            ap_q    <= '0;
            ax_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dms_q   <= dms_d;
            dml_q   <= dml_d;
            y_q     <= y_d;
            tdp_q   <= tdp_d;
            tr_q    <= tr_d;
            ap_q    <= ap_d;
            ax_q    <= ax_d;
            done_q  <= done_d;
        end
    end

    assign DMS  = dms_q;
    assign DML  = dml_q;
    assign AP   = ap_q;
    assign AX   = ax_q;
    assign AL   = (ap_q >= AP_TRIG_C) ? 7'd64 : ap_q[8:2];
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_adapt_speed_state.sv
// tb/tb_adapt_speed_state.sv - self-checking bench for adapt_speed_state with an integer reference model
module tb_adapt_speed_state;

    logic        clk = 1'b0;
    logic        reset;
    logic        samp_en;
    logic [11:0] DMSP;
    logic [13:0] DMLP;
    logic [12:0] Y;
    logic        TDP;
    logic        TR;
    logic [11:0] DMS;
    logic [13:0] DML;
    logic [9:0]  AP;
    logic [6:0]  AL;
    logic        AX;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    adapt_speed_state dut (
        .clk(clk), .reset(reset), .samp_en(samp_en),
        .DMSP(DMSP), .DMLP(DMLP), .Y(Y), .TDP(TDP), .TR(TR),
        .DMS(DMS), .DML(DML), .AP(AP), .AL(AL), .AX(AX),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sample takes three clocks; results follow the integer rules.
    int m_phase, m_dms, m_dml, m_y, m_tdp, m_tr, m_ap, m_ax, m_done;

    function automatic int model_ax(int dmsp, int dmlp, int y, int tdp);
        int dif, difm, tdpg;
        dif  = (dmsp * 4 + 32768 - dmlp) % 65536;
        difm = (dif >= 32768) ? (65536 - dif) % 32768 : dif;
`ifdef TONE_DET_EN
        tdpg = tdp;
`else
        tdpg = 0;
`endif
        return (y >= 1536 && difm < dmlp / 8 && tdpg == 0) ? 0 : 1;
    endfunction

    function automatic int model_ap(int ax, int ap, int tr);
        int d, dsx;
        d   = (ax * 512 + 2048 - ap) % 2048;
        dsx = (d >= 1024) ? d / 16 + 896 : d / 16;
        return tr ? 256 : (dsx + ap) % 1024;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_dms = 0; m_dml = 0; m_y = 0; m_tdp = 0; m_tr = 0;
            m_ap = 0; m_ax = 0; m_done = 0;
        end else begin
            m_done = (m_phase == 2) ? 1 : 0;
            if (m_phase == 0 && samp_en) begin
                m_dms = DMSP; m_dml = DMLP; m_y = Y; m_tdp = TDP; m_tr = TR;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_ax = model_ax(m_dms, m_dml, m_y, m_tdp);
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_ap = model_ap(m_ax, m_ap, m_tr);
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("DMS", DMS, m_dms);
        chk("DML", DML, m_dml);
        chk("AP", AP, m_ap);
        chk("AL", AL, (m_ap >= 256) ? 64 : m_ap / 4);
        chk("AX", AX, m_ax);
        chk("busy", busy, (m_phase != 0) ? 1 : 0);
        chk("done", done, m_done);
    end

    task automatic drive(input int a, input int b, input int c, input int d, input int e);
        DMSP = 12'(a); DMLP = 14'(b); Y = 13'(c); TDP = d[0]; TR = e[0];
    endtask

    task automatic do_sample(input int a, input int b, input int c, input int d, input int e);
        @(negedge clk);
        drive(a, b, c, d, e);
        samp_en = 1'b1;
        @(negedge clk);
        samp_en = 1'b0;
        for (int k = 0; k < 6 && !done; k++) @(negedge clk);
        chk("done_wait", done, 1);
    endtask

    int vec [5][5] = '{
        '{4095,     0, 8191, 0, 0},
        '{   0, 16383, 8191, 0, 0},
        '{1000,  4000, 1600, 0, 0},
        '{1023,  4000, 1600, 0, 1},
        '{  50,  2000, 1535, 0, 0}
    };

    initial begin
        reset = 1'b1;
        samp_en = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Fast adapt from reset
        do_sample(0, 0, 2000, 0, 0);
        chk("T2_AX", AX, 1);
        chk("T2_AP", AP, 32);
        chk("T2_AL", AL, 8);

        // Slow adapt
        do_sample(200, 800, 1536, 0, 0);
        chk("T3_AX", AX, 0);
        chk("T3_AP", AP, 30);
        chk("T3_DMS", DMS, 200);
        chk("T3_DML", DML, 800);

        // Transition, then fast adapt above the trigger point
        do_sample(5, 5, 0, 0, 1);
        chk("T4_AP", AP, 256);
        chk("T4_AL", AL, 64);
        do_sample(0, 0, 0, 0, 0);
        chk("T4b_AP", AP, 272);
        chk("T4b_AL", AL, 64);

        // Tone detect
        do_sample(200, 800, 1536, 1, 0);
`ifdef TONE_DET_EN
        chk("T5_AX", AX, 1);
`else
        chk("T5_AX", AX, 0);
`endif

        foreach (vec[i]) do_sample(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4]);

        // Asynchronous reset away from any clock edge
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("T1_DMS", DMS, 0);
        chk("T1_DML", DML, 0);
        chk("T1_AP", AP, 0);
        chk("T1_AL", AL, 0);
        chk("T1_AX", AX, 0);
        chk("T1_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        do_sample(0, 0, 2000, 0, 0);
        chk("T6_pre_AP", AP, 32);

        // samp_en during CMP is ignored
        @(negedge clk);
        drive(100, 300, 2000, 0, 0);
        samp_en = 1'b1;
        @(negedge clk);
        drive(7, 9, 0, 0, 1);
        @(negedge clk);
        samp_en = 1'b0;
        for (int k = 0; k < 6 && !done; k++) @(negedge clk);
        chk("T6_done", done, 1);
        chk("T6_DMS", DMS, 100);
        chk("T6_DML", DML, 300);

        // Reset while in FILT discards the sample
        @(negedge clk);
        drive(100, 300, 2000, 0, 1);
        samp_en = 1'b1;
        @(negedge clk);
        samp_en = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("T6r_AP", AP, 0);
        chk("T6r_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("T6r_no_done", done, 0);
        end
        chk("T6r_AP_after", AP, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
